// File: rtl/ldpc_decode_scheduler_if.sv
// Control bundle between frame-level control / datapath (master) and the LDPC decode
// scheduler (slave).
interface ldpc_decode_scheduler_if #(
  parameter int LOG2M  = 3,
  parameter int ITER_W = 5
);
  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              abort;
  logic              syn_valid;
  logic              syn_ok;
  logic              init_en;
  logic              chk_en;
  logic [LOG2M-1:0]  chk_row;
  logic              var_en;
  logic              syn_req;
  logic              busy;
  logic [ITER_W-1:0] iter_count;
  logic              done;
  logic              success;
  logic [2:0]        state;

  modport master (
    output start, max_iter, abort, syn_valid, syn_ok,
    input  init_en, chk_en, chk_row, var_en, syn_req, busy, iter_count, done, success, state
  );

  modport slave (
    input  start, max_iter, abort, syn_valid, syn_ok,
    output init_en, chk_en, chk_row, var_en, syn_req, busy, iter_count, done, success, state
  );
endinterface

// File: rtl/ldpc_decode_scheduler.sv
// Sequences one LDPC codeword decode: init, M check-row updates and a variable-node
// update per iteration, then waits on the syndrome to stop or iterate again.
module ldpc_decode_scheduler #(
  parameter int LOG2M  = 3,
  parameter int M      = 6,
  parameter int ITER_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ldpc_decode_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_VAR   = 3'd3,
    S_SYND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [LOG2M-1:0] ROW_LAST = LOG2M'(M - 1);

  state_t            state_q, state_d;
  logic [LOG2M-1:0]  chk_row_q, chk_row_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic              success_q, success_d;
  logic              accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      chk_row_q <= '0;
      iter_q    <= '0;
      limit_q   <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chk_row_q <= chk_row_d;
      iter_q    <= iter_d;
      limit_q   <= limit_d;
      success_q <= success_d;
    end
  end

  // Abort takes priority over every other exit from the active states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_INIT;
      S_INIT:  state_d = bus.abort ? S_DONE : S_CHECK;
      S_CHECK: begin
        if (bus.abort)                  state_d = S_DONE;
        else if (chk_row_q == ROW_LAST) state_d = S_VAR;
      end
      S_VAR:   state_d = bus.abort ? S_DONE : S_SYND;
      S_SYND: begin
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (bus.syn_valid) begin
          if (bus.syn_ok || (iter_q == limit_q)) state_d = S_DONE;
          else                                  state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state_q == S_IDLE) && bus.start;
    chk_row_d = ((state_q == S_CHECK) && (state_d == S_CHECK)) ? chk_row_q + LOG2M'(1) : '0;
    iter_d    = iter_q;
    limit_d   = limit_q;
    success_d = success_q;
    if (accept) begin
      iter_d    = '0;
      limit_d   = (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
      success_d = 1'b0;
    end else begin
      if ((state_q == S_VAR) && (state_d == S_SYND)) iter_d = iter_q + ITER_W'(1);
      if ((state_q == S_SYND) && !bus.abort && bus.syn_valid && bus.syn_ok) success_d = 1'b1;
    end
  end

  logic init_en, chk_en, var_en, syn_req, busy, done;

  always_comb begin
    init_en = (state_q == S_INIT);
    chk_en  = (state_q == S_CHECK);
    var_en  = (state_q == S_VAR);
    syn_req = (state_q == S_SYND);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
  end

  assign bus.init_en    = init_en;
  assign bus.chk_en     = chk_en;
  assign bus.chk_row    = chk_row_q;
  assign bus.var_en     = var_en;
  assign bus.syn_req    = syn_req;
  assign bus.busy       = busy;
  assign bus.iter_count = iter_q;
  assign bus.done       = done;
  assign bus.success    = success_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ldpc_decode_scheduler.sv
// Self-checking bench for ldpc_decode_scheduler: directed and randomized decodes checked
// cycle by cycle against a timeline model of the decode.
module tb_ldpc_decode_scheduler;
  localparam int LOG2M  = 3;
  localparam int M      = 6;
  localparam int ITER_W = 5;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ldpc_decode_scheduler_if #(.LOG2M(LOG2M), .ITER_W(ITER_W)) bus ();

  ldpc_decode_scheduler #(.LOG2M(LOG2M), .M(M), .ITER_W(ITER_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Iterations whose VAR cycle lies strictly before cycle c (start accepted at edge 0).
  function automatic int vars_before(input int c, input int p);
    if (c <= M + 2) return 0;
    return (c - (M + 2) - 1) / p + 1;
  endfunction

  // One decode: mi = max_iter, ok_it = iteration whose syndrome passes (0 = never),
  // d = syndrome latency in cycles, a = cycle at which abort is driven (-1 = none).
  task automatic run_decode(input string tag, input int mi, input int ok_it, input int d,
                            input int a, input bit noise);
    int L, P, n_nat, done_c, iter_fin, mism, first_bad, vars_seen, wait_cnt, t, ph, row, nd;
    bit succ;
    L        = (mi == 0) ? 1 : mi;
    P        = M + d + 2;
    succ     = (ok_it >= 1) && (ok_it <= L);
    n_nat    = succ ? ok_it : L;
    done_c   = M + 2 + (n_nat - 1) * P + d + 2;
    iter_fin = n_nat;
    if (a >= 1 && a < done_c) begin
      done_c   = a + 1;
      succ     = 1'b0;
      iter_fin = vars_before(a, P);
    end

    bus.max_iter  = ITER_W'(mi);
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    bus.syn_valid = 1'b0;
    bus.syn_ok    = 1'b0;
    tick();
    mism = 0; first_bad = -1; vars_seen = 0; wait_cnt = 0;
    for (int c = 1; c < done_c; c++) begin
      if (c == 1) begin
        ph = 1; row = 0;
      end else begin
        t   = (c - 2) % P;
        ph  = (t < M) ? 2 : ((t == M) ? 3 : 4);
        row = (t < M) ? t : 0;
      end
      nd = vars_before(c, P);
      if (bus.state !== 3'(ph) || bus.init_en !== (ph == 1) || bus.chk_en !== (ph == 2) ||
          bus.var_en !== (ph == 3) || bus.syn_req !== (ph == 4) || bus.chk_row !== LOG2M'(row) ||
          bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.success !== 1'b0 ||
          bus.iter_count !== ITER_W'(nd)) begin
        mism++;
        if (first_bad < 0) first_bad = c;
      end
      // Datapath responder plus optional protocol noise.
      bus.abort = (c == a);
      if (bus.var_en === 1'b1) vars_seen++;
      if (bus.syn_req === 1'b1) begin
        if (wait_cnt == d) begin
          bus.syn_valid = 1'b1;
          bus.syn_ok    = (vars_seen == ok_it);
          wait_cnt      = 0;
        end else begin
          bus.syn_valid = 1'b0;
          bus.syn_ok    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          wait_cnt++;
        end
      end else begin
        wait_cnt      = 0;
        bus.syn_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.syn_ok    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    chk($sformatf("%s seq first_bad_cycle=%0d", tag, first_bad), mism, 0);
    chk({tag, " done"},       bus.done, 1);
    chk({tag, " done_state"}, bus.state, 5);
    chk({tag, " success"},    bus.success, succ);
    chk({tag, " iter"},       bus.iter_count, iter_fin);
    // start/abort/syn_valid presented during DONE must be ignored.
    bus.start = noise; bus.abort = noise; bus.syn_valid = noise; bus.syn_ok = noise;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0; bus.syn_valid = 1'b0; bus.syn_ok = 1'b0;
    chk({tag, " idle_state"},   bus.state, 0);
    chk({tag, " idle_busy"},    bus.busy, 0);
    chk({tag, " idle_done"},    bus.done, 0);
    chk({tag, " success_hold"}, bus.success, succ);
    chk({tag, " iter_hold"},    bus.iter_count, iter_fin);
    $display("decode %s max_iter=%0d ok_it=%0d dly=%0d abort=%0d -> success=%0d iter=%0d",
             tag, mi, ok_it, d, a, bus.success, bus.iter_count);
  endtask

  initial begin
    int mi, ok, dl, ab;
    bit nz;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.max_iter = '0; bus.abort = 1'b0;
    bus.syn_valid = 1'b0; bus.syn_ok = 1'b0;
    tick(); tick();
    chk("rst state",   bus.state, 0);
    chk("rst busy",    bus.busy, 0);
    chk("rst enables", {bus.init_en, bus.chk_en, bus.var_en, bus.syn_req, bus.done}, 0);
    chk("rst row",     bus.chk_row, 0);
    chk("rst iter",    bus.iter_count, 0);
    chk("rst success", bus.success, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst idle", bus.state, 0);

    run_decode("early",   10, 1, 0, -1, 1'b0);
    run_decode("b2b",      5, 2, 1, -1, 1'b0);
    run_decode("limit3",   3, 0, 2, -1, 1'b0);
    run_decode("limit0",   0, 0, 1, -1, 1'b0);
    run_decode("limit31", 31, 0, 0, -1, 1'b0);
    run_decode("abort_row2", 10, 0, 0, 4, 1'b0);
    run_decode("abort_synd", 10, 1, 3, 12, 1'b0);
    run_decode("abort_init",  4, 1, 0, 1, 1'b0);
    run_decode("noise_dly20", 4, 3, 20, -1, 1'b1);

    // Reset in the middle of CHECK aborts silently.
    bus.max_iter = 5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("mid_rst pre chk_en", bus.chk_en, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst done1", bus.done, 0);
    tick();
    chk("mid_rst state", bus.state, 0);
    chk("mid_rst busy",  bus.busy, 0);
    chk("mid_rst chk_en", bus.chk_en, 0);
    chk("mid_rst iter",  bus.iter_count, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst after state", bus.state, 0);
    chk("mid_rst after done",  bus.done, 0);

    for (int k = 0; k < 10; k++) begin
      mi = $urandom_range(0, 7);
      ok = $urandom_range(0, 8);
      dl = $urandom_range(0, 4);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1;
      nz = 1'($urandom_range(0, 1));
      run_decode($sformatf("rnd%0d", k), mi, ok, dl, ab, nz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
